// File: rtl/register_file_pkg.sv
// Shared definitions for the two-read/one-write register file:
// clear-engine state encoding and default geometry.
package register_file_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int DEFAULT_REGISTER_COUNT = 16;
    localparam int DEFAULT_REGISTER_SIZE  = 8;

endpackage

// File: rtl/register_read_port.sv
// One synchronous read port: range check, write-first / clear-first bypass,
// registered data and a one-cycle valid strobe.
module register_read_port #(
    parameter int register_count = 16,
    parameter int register_size  = 8,
    parameter int addr_width     = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rd_en,
    input  logic [addr_width-1:0]    rd_addr,
    input  logic [register_size-1:0] mem_word,
    input  logic                     wr_commit,
    input  logic [addr_width-1:0]    wr_addr,
    input  logic [register_size-1:0] wr_data,
    input  logic                     clr_active,
    input  logic [addr_width-1:0]    clr_index,
    output logic [register_size-1:0] rd_data,
    output logic                     rd_valid
);

    localparam logic [addr_width:0] COUNT_EXT = (addr_width + 1)'(register_count);

    logic                     in_range;
    logic [register_size-1:0] next_data;

    assign in_range = ({1'b0, rd_addr} < COUNT_EXT);

    // Writes and clears are mutually exclusive (IDLE vs CLEAR), so the
    // priority between the two bypasses never matters in practice.
    always_comb begin
        next_data = mem_word;
        if (!in_range) begin
            next_data = '0;
        end else if (wr_commit && (wr_addr == rd_addr)) begin
            next_data = wr_data;
        end else if (clr_active && (clr_index == rd_addr)) begin
            next_data = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= next_data;
            end
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// Register file with two independent read ports, one write port and a
// sequential bulk-clear engine that zeroes one register per cycle.
module register_file_2r1w
    import register_file_pkg::*;
#(
    parameter int register_count = DEFAULT_REGISTER_COUNT,
    parameter int register_size  = DEFAULT_REGISTER_SIZE,
    localparam int addr_width    = $clog2(register_count)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rd_en_a,
    input  logic [addr_width-1:0]    rd_addr_a,
    output logic [register_size-1:0] rd_data_a,
    output logic                     rd_valid_a,
    input  logic                     rd_en_b,
    input  logic [addr_width-1:0]    rd_addr_b,
    output logic [register_size-1:0] rd_data_b,
    output logic                     rd_valid_b,
    input  logic                     wr_en,
    input  logic [addr_width-1:0]    wr_addr,
    input  logic [register_size-1:0] wr_data,
    input  logic                     clear,
    output logic                     busy,
    output logic                     wr_err,
    output state_t                   fsm_state
);

    localparam logic [addr_width:0]   COUNT_EXT = (addr_width + 1)'(register_count);
    localparam logic [addr_width-1:0] LAST_IDX  = addr_width'(register_count - 1);

    logic [register_size-1:0] regs [register_count];
    state_t                   state;
    logic [addr_width-1:0]    clr_index;
    logic                     wr_in_range;
    logic                     wr_commit;
    logic                     clr_active;
    logic [register_size-1:0] word_a;
    logic [register_size-1:0] word_b;

    assign wr_in_range = ({1'b0, wr_addr} < COUNT_EXT);
    assign clr_active  = (state == ST_CLEAR);
    assign wr_commit   = wr_en && wr_in_range && !clr_active;
    assign busy        = clr_active;
    assign fsm_state   = state;
    assign word_a      = regs[rd_addr_a];
    assign word_b      = regs[rd_addr_b];

    // A write and a clear request in the same IDLE cycle both take effect:
    // the write lands now and the engine zeroes that register later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            clr_index <= '0;
            wr_err    <= 1'b0;
            for (int i = 0; i < register_count; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_err <= clr_active && wr_en && wr_in_range;
            case (state)
                ST_IDLE: begin
                    if (wr_commit) begin
                        regs[wr_addr] <= wr_data;
                    end
                    if (clear) begin
                        state     <= ST_CLEAR;
                        clr_index <= '0;
                    end
                end
                ST_CLEAR: begin
                    regs[clr_index] <= '0;
                    if (clr_index == LAST_IDX) begin
                        state     <= ST_IDLE;
                        clr_index <= '0;
                    end else begin
                        clr_index <= clr_index + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    register_read_port #(
        .register_count(register_count),
        .register_size (register_size),
        .addr_width    (addr_width)
    ) u_port_a (
        .clock     (clock),
        .reset     (reset),
        .rd_en     (rd_en_a),
        .rd_addr   (rd_addr_a),
        .mem_word  (word_a),
        .wr_commit (wr_commit),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_active(clr_active),
        .clr_index (clr_index),
        .rd_data   (rd_data_a),
        .rd_valid  (rd_valid_a)
    );

    register_read_port #(
        .register_count(register_count),
        .register_size (register_size),
        .addr_width    (addr_width)
    ) u_port_b (
        .clock     (clock),
        .reset     (reset),
        .rd_en     (rd_en_b),
        .rd_addr   (rd_addr_b),
        .mem_word  (word_b),
        .wr_commit (wr_commit),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_active(clr_active),
        .clr_index (clr_index),
        .rd_data   (rd_data_b),
        .rd_valid  (rd_valid_b)
    );

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed and randomized bench for register_file_2r1w; a per-cycle model
// of the register contents and clear progress predicts every output.
module tb_register_file_2r1w;
    import register_file_pkg::*;

    localparam int N = 16;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         rd_en_a = 1'b0, rd_en_b = 1'b0, wr_en = 1'b0, clear = 1'b0;
    logic [3:0]   rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] rd_data_a, rd_data_b;
    logic         rd_valid_a, rd_valid_b, busy, wr_err;
    state_t       fsm_state;

    int checks   = 0;
    int failures = 0;

    // Reference model: register contents plus clear progress.
    logic [W-1:0] m_mem [N];
    bit           m_busy;
    int           m_idx;
    logic [W-1:0] exp_a, exp_b;
    logic         exp_va, exp_vb, exp_err;

    register_file_2r1w dut (
        .clock     (clock),
        .reset     (reset),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_valid_a(rd_valid_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_valid_b(rd_valid_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clear     (clear),
        .busy      (busy),
        .wr_err    (wr_err),
        .fsm_state (fsm_state)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        m_busy = 0; m_idx = 0;
        exp_a = '0; exp_b = '0; exp_va = 0; exp_vb = 0; exp_err = 0;
    endtask

    task automatic check_all();
        chk("rd_data_a", rd_data_a, exp_a);
        chk("rd_valid_a", rd_valid_a, exp_va);
        chk("rd_data_b", rd_data_b, exp_b);
        chk("rd_valid_b", rd_valid_b, exp_vb);
        chk("busy", busy, m_busy);
        chk("wr_err", wr_err, exp_err);
        chk("fsm_state", fsm_state, m_busy ? ST_CLEAR : ST_IDLE);
    endtask

    // One clock: drive inputs, advance the model at the edge, check outputs.
    // A read observes the array as it stands after this edge's write/clear.
    task automatic cycle(input logic ea, input logic [3:0] aa, input logic eb,
                         input logic [3:0] ab, input logic we, input logic [3:0] wa,
                         input logic [W-1:0] wd, input logic clr);
        bit was_busy;
        rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
        wr_en = we; wr_addr = wa; wr_data = wd; clear = clr;
        @(posedge clock);
        was_busy = m_busy;
        if (was_busy) begin
            m_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == N) m_busy = 0;
        end
        exp_err = we && was_busy;
        if (we && !was_busy) m_mem[wa] = wd;
        exp_va = ea;
        exp_vb = eb;
        if (ea) exp_a = m_mem[aa];
        if (eb) exp_b = m_mem[ab];
        if (clr && !was_busy) begin
            m_busy = 1; m_idx = 0;
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_rd_data_a", rd_data_a, 0);
        chk("rst_rd_data_b", rd_data_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", fsm_state, ST_IDLE);
        chk("rst_wr_err", wr_err, 0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int n;
        logic [3:0] a, b, wa;
        model_reset();

        // Power-on reset
        repeat (2) @(negedge clock);
        #1;
        check_all();
        reset = 1'b1;

        // Reset wipes stored data
        cycle(0, 0, 0, 0, 1, 3, 8'hA5, 0);
        cycle(1, 3, 0, 0, 0, 0, '0, 0);
        chk("pre_rst_r3", rd_data_a, 8'hA5);
        pulse_reset();
        cycle(1, 3, 1, 3, 0, 0, '0, 0);
        chk("post_rst_r3", rd_data_a, 8'h00);

        // Dual read, then idle cycle drops both valids
        cycle(0, 0, 0, 0, 1, 2, 8'h11, 0);
        cycle(0, 0, 0, 0, 1, 9, 8'h22, 0);
        cycle(1, 2, 1, 9, 0, 0, '0, 0);
        chk("dual_a", rd_data_a, 8'h11);
        chk("dual_b", rd_data_b, 8'h22);
        idle();
        chk("dual_va_drop", rd_valid_a, 0);
        chk("dual_hold_a", rd_data_a, 8'h11);

        // Write-first bypass
        cycle(0, 0, 0, 0, 1, 5, 8'h33, 0);
        cycle(1, 5, 0, 0, 1, 5, 8'h44, 0);
        chk("bypass_a", rd_data_a, 8'h44);
        cycle(0, 0, 1, 5, 0, 0, '0, 0);
        chk("after_bypass_b", rd_data_b, 8'h44);

        // Bulk clear with a read at busy cycle 3 and a dropped write at cycle 2;
        // clear is held high throughout to show it is ignored while busy.
        for (int i = 0; i < N; i++) cycle(0, 0, 0, 0, 1, 4'(i), 8'hFF, 0);
        cycle(0, 0, 0, 0, 0, 0, '0, 1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 2) cycle(0, 0, 0, 0, 1, 7, 8'h5A, 1);
            else if (n == 3) cycle(1, 15, 1, 0, 0, 0, '0, 1);
            else cycle(0, 0, 0, 0, 0, 0, '0, 1);
            if (n == 2) chk("wr_err_pulse", wr_err, 1);
            if (n == 3) begin
                chk("clr_r15_old", rd_data_a, 8'hFF);
                chk("clr_r0_zero", rd_data_b, 8'h00);
                chk("wr_err_single", wr_err, 0);
            end
        end
        chk("busy_len", n, N);
        idle();
        for (int i = 0; i < N; i += 2) cycle(1, 4'(i), 1, 4'(i + 1), 0, 0, '0, 0);
        cycle(1, 7, 0, 0, 0, 0, '0, 0);
        chk("r7_after_clear", rd_data_a, 8'h00);

        // Back-to-back dropped writes hold wr_err high
        cycle(0, 0, 0, 0, 0, 0, '0, 1);
        cycle(0, 0, 0, 0, 1, 1, 8'h01, 0);
        cycle(0, 0, 0, 0, 1, 2, 8'h02, 0);
        chk("wr_err_b2b", wr_err, 1);
        while (busy === 1'b1 && m_busy) idle();

        // Write and clear in the same IDLE cycle
        cycle(0, 0, 0, 0, 1, 4, 8'h77, 1);
        cycle(1, 4, 0, 0, 0, 0, '0, 0);
        chk("wr_then_clear_r4", rd_data_a, 8'h77);
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; idle(); end
        cycle(1, 4, 0, 0, 0, 0, '0, 0);
        chk("r4_cleared", rd_data_a, 8'h00);

        // Reset on busy cycle 5 aborts; the next clear starts at index 0
        for (int i = 0; i < N; i++) cycle(0, 0, 0, 0, 1, 4'(i), 8'(i + 1), 0);
        cycle(0, 0, 0, 0, 0, 0, '0, 1);
        repeat (4) idle();
        chk("busy_before_abort", busy, 1);
        pulse_reset();
        for (int i = 0; i < N; i++) cycle(0, 0, 0, 0, 1, 4'(i), 8'(i + 1), 0);
        cycle(0, 0, 0, 0, 0, 0, '0, 1);
        cycle(1, 0, 1, 1, 0, 0, '0, 0);
        chk("restart_r0", rd_data_a, 8'h00);
        chk("restart_r1", rd_data_b, 8'h02);
        n = 1;
        while (busy === 1'b1 && n < 40) begin n++; idle(); end
        chk("restart_busy_len", n, N);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wa = 4'($urandom_range(0, N - 1));
            a  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, N - 1));
            b  = ($urandom_range(0, 3) == 0) ? a  : 4'($urandom_range(0, N - 1));
            cycle(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), b,
                  1'($urandom_range(0, 1)), wa, 8'($urandom),
                  ($urandom_range(0, 59) == 0));
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; idle(); end
        for (int i = 0; i < N; i += 2) cycle(1, 4'(i), 1, 4'(i + 1), 0, 0, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
